// File: rtl/shifter_pkg.sv
// Shared types and constants for the universal shift register with burst sequencer.
package shifter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_univ_if.sv
// Control/data bundle between a controller (master) and the shift register (slave).
interface shift_seq_univ_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);

  logic             En;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Step;
  logic             Start;
  logic [CNT_W-1:0] Amt;
  logic             Dir;
  logic             SerIn;
  logic             Rot;
  logic [WIDTH-1:0] Q;
  logic             SerOut;
  logic             Busy;
  logic             Done;

  modport master (
    output En, Load, D, Step, Start, Amt, Dir, SerIn, Rot,
    input  Q, SerOut, Busy, Done
  );

  modport slave (
    input  En, Load, D, Step, Start, Amt, Dir, SerIn, Rot,
    output Q, SerOut, Busy, Done
  );

endinterface

// File: rtl/shift_counter.sv
// Loadable down counter with enable and an is-one flag, used to count burst shifts.
module shift_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             is_one_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register; synchronous reset overrides the enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq_univ.sv
// Universal shift register with parallel load, single step and counted burst shift.
// Optional feature macro: SHIFTER_ROTATE_EN (Rot=1 feeds the outgoing bit back as fill).
module shift_seq_univ
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic           Clk,
  input logic           Reset,
  shift_seq_univ_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  logic             dir_q, dir_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_is_one;
  logic [CNT_W-1:0] cnt_val;

  logic             do_shift;
  logic             shift_dir;
  logic             shift_out;
  logic             fill;

  shift_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .en_i       (bus.En),
    .load_i     (cnt_load),
    .load_val_i (bus.Amt),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .is_one_o   (cnt_is_one)
  );

  // Counter value is only consumed through its is-one flag.
  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

  // Bit leaving the register for the direction in use this cycle.
  always_comb begin
    shift_out = (shift_dir == DIR_LEFT) ? q_q[WIDTH-1] : q_q[0];
  end

`ifdef SHIFTER_ROTATE_EN
  // Rotate feeds the outgoing bit back in; Rot is sampled live on every shift.
  always_comb begin
    fill = bus.Rot ? shift_out : bus.SerIn;
  end
`else
  logic unused_rot;
  assign unused_rot = bus.Rot;

  // Without rotate support the fill is always the serial input.
  always_comb begin
    fill = bus.SerIn;
  end
`endif

  // Sequencer next-state and datapath next values.
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    dir_d     = dir_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    do_shift  = 1'b0;
    shift_dir = bus.Dir;

    unique case (state_q)
      StIdle: begin
        // Start > Load > Step; lower-priority requests are dropped.
        if (bus.Start) begin
          cnt_load = 1'b1;
          dir_d    = bus.Dir;
          state_d  = (bus.Amt != '0) ? StShift : StDone;
        end else if (bus.Load) begin
          q_d = bus.D;
        end else if (bus.Step) begin
          do_shift = 1'b1;
        end
      end
      StShift: begin
        do_shift  = 1'b1;
        shift_dir = dir_q;
        cnt_dec   = 1'b1;
        if (cnt_is_one) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (do_shift) begin
      ser_out_d = shift_out;
      if (shift_dir == DIR_LEFT) begin
        q_d = {q_q[WIDTH-2:0], fill};
      end else begin
        q_d = {fill, q_q[WIDTH-1:1]};
      end
    end
  end

  // State registers; reset wins over En, En low freezes everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      dir_q     <= DIR_RIGHT;
    end else if (bus.En) begin
      state_q   <= state_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      dir_q     <= dir_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.Q      = q_q;
    bus.SerOut = ser_out_q;
    bus.Busy   = (state_q == StShift);
    bus.Done   = (state_q == StDone);
  end

endmodule

// File: doc/shift_seq_univ.md
# shift_seq_univ

Parametrised universal shift register with a built-in shift sequencer; successor to the fixed 8-bit bidirectional serial shifter. Supports parallel load, single-step shift and a counted burst shift, with busy/done handshake. Intended as the serialiser/deserialiser and bit-alignment stage in the datapath labs, driven by a controller FSM.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), width of the burst-count input

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high; overrides everything including En
- En  in  1  global clock enable; low freezes all state
- Load  in  1  parallel load request (IDLE only)
- D  in  WIDTH  parallel load data
- Step  in  1  single shift request (IDLE only)
- Start  in  1  burst shift request (IDLE only)
- Amt  in  CNT_W  burst shift count, sampled with Start
- Dir  in  1  0 = right (fill at MSB), 1 = left (fill at LSB)
- SerIn  in  1  serial fill bit, sampled live on every shift edge
- Rot  in  1  rotate select (used only with SHIFTER_ROTATE_EN)
- Q  out  WIDTH  register contents
- SerOut  out  1  registered copy of the bit most recently shifted out
- Busy  out  1  high in SHIFT state
- Done  out  1  high in DONE state

## Operation
- Reset=1 at an edge: Q=0, SerOut=0, state IDLE, counter=0, latched dir=0; Busy=Done=0.
- En=0: no register changes (Q, SerOut, state, counter, latched dir hold). Outputs keep their values.
- Right shift: Q <= {fill, Q[WIDTH-1:1]}, SerOut <= Q[0]. Left shift: Q <= {Q[WIDTH-2:0], fill}, SerOut <= Q[WIDTH-1]. fill = SerIn.
- States: IDLE, SHIFT, DONE.
- IDLE, priority Start > Load > Step (lower-priority requests in the same cycle are dropped):
  - Start: counter <= Amt, latch Dir; Amt≠0 -> SHIFT, Amt=0 -> DONE. Q unchanged.
  - Load: Q <= D, stay IDLE; SerOut unchanged.
  - Step: one shift using live Dir, stay IDLE.
- SHIFT: each enabled edge performs one shift using latched dir and decrements counter; the edge with counter=1 goes to DONE. Load/Step/Start ignored; Dir changes ignored.
- DONE: one enabled cycle, then IDLE. Requests ignored.
- Amt > WIDTH is legal: shifts continue Amt times (Q fully replaced by fill bits).

## Timing
- Load/Step: result on Q one cycle after the request edge.
- Burst, Start sampled at edge t (all edges enabled): Busy=1 after edges t..t+Amt-1; shifts on edges t+1..t+Amt; Done=1 for one cycle after edge t+Amt; IDLE after edge t+Amt+1. Amt=0: Done=1 after edge t, IDLE after t+1.
- Each En=0 cycle stretches the sequence by one cycle; Done stays high across En=0 cycles in DONE.
- Reset mid-burst: IDLE, Q=0 on the next edge; no Done pulse.
- No combinational path from inputs to outputs.

## Configuration
- SHIFTER_ROTATE_EN defined: when Rot=1 at a shift edge, fill = the outgoing bit (rotate); Rot sampled live, in both Step and burst.
- Undefined: Rot port present but ignored; fill is always SerIn.

## Structure
- Package shifter_pkg: state enum (IDLE, SHIFT, DONE), DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
- Sub-module shift_counter: CNT_W-bit loadable down counter with enable, load and is-one flag; used by the sequencer FSM.

## Test plan
- Reset=1 with arbitrary inputs -> Q=8'h00, SerOut=0, Busy=0, Done=0; held while Reset=1 even with Start=1.
- Load D=8'hA5; Start Amt=3, Dir=0, SerIn=1 -> Busy 3 cycles, Q=8'hF4, SerOut=1, Done one cycle, then IDLE.
- Load 8'h81; Step Dir=1, SerIn=0 -> Q=8'h02, SerOut=1; Start+Load same cycle -> Load dropped.
- Start Amt=0 -> no Busy, Done one cycle later, Q unchanged; Start during SHIFT/DONE ignored.
- Burst Amt=4 with En=0 for 2 mid-burst cycles -> Q frozen those cycles, Done delayed 2 cycles; repeat with Reset mid-burst -> Q=0, IDLE, no Done.
- Q=8'h81, Start Amt=1, Dir=0, Rot=1, SerIn=0 -> 8'hC0 with SHIFTER_ROTATE_EN, 8'h40 without.
